// File: rtl/exception_unit.sv
// Exception/interrupt controller for the LEGv8 core: invalid-op,
// ERET and external IRQ entry, handler tracking and double-fault halt.
module exception_unit #(
  parameter int          N_IRQ      = 4,
  parameter int          PC_W       = 64,
  parameter logic [63:0] EXC_VECTOR = 64'h0000_0000_0000_00D8,
  parameter int          ID_W       = (N_IRQ > 1) ? $clog2(N_IRQ) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             instr_valid,
  input  logic             not_an_instr,
  input  logic             eret_in,
  input  logic [PC_W-1:0]  pc_in,
  input  logic [N_IRQ-1:0] irq_req,
  input  logic             mask_we,
  input  logic [N_IRQ-1:0] mask_wdata,
  output logic             redirect,
  output logic [PC_W-1:0]  redirect_pc,
  output logic [PC_W-1:0]  elr,
  output logic [3:0]       esr,
  output logic [ID_W-1:0]  irq_id,
  output logic [N_IRQ-1:0] irq_ack,
  output logic             in_handler,
  output logic             halted
);

  localparam logic [PC_W-1:0] VEC = PC_W'(EXC_VECTOR);

  localparam logic [3:0] ESR_NONE = 4'b0000;
  localparam logic [3:0] ESR_IRQ  = 4'b0001;
  localparam logic [3:0] ESR_ILL  = 4'b0010;
  localparam logic [3:0] ESR_ERET = 4'b0011;
  localparam logic [3:0] ESR_DBL  = 4'b0100;

  typedef enum logic [1:0] {
    S_RUN,
    S_HANDLER,
    S_HALT
  } state_e;

  state_e           state_q, state_d;
  logic [N_IRQ-1:0] pending_q, pending_d;
  logic [N_IRQ-1:0] enable_q, enable_d;
  logic [N_IRQ-1:0] prev_q, prev_d;
  logic             redirect_q, redirect_d;
  logic [PC_W-1:0]  rpc_q, rpc_d;
  logic [PC_W-1:0]  elr_q, elr_d;
  logic [3:0]       esr_q, esr_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic [N_IRQ-1:0] ack_q, ack_d;
  logic             inh_q, inh_d;
  logic             halt_q, halt_d;

  logic [N_IRQ-1:0] rise;
  logic [N_IRQ-1:0] cand;
  logic             irq_hit;
  logic [ID_W-1:0]  irq_sel;
  logic [N_IRQ-1:0] irq_oh;

  // A rising edge seen this cycle is already eligible for entry.
  assign rise = irq_req & ~prev_q;
  assign cand = (pending_q | rise) & enable_q;

  always_comb begin
    irq_hit = 1'b0;
    irq_sel = '0;
    irq_oh  = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (cand[i]) begin
        irq_hit    = 1'b1;
        irq_sel    = ID_W'(i);
        irq_oh     = '0;
        irq_oh[i]  = 1'b1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    redirect_d = 1'b0;
    rpc_d      = rpc_q;
    elr_d      = elr_q;
    esr_d      = esr_q;
    id_d       = id_q;
    ack_d      = '0;
    inh_d      = inh_q;
    halt_d     = halt_q;
    pending_d  = (pending_q & ~ack_q) | rise;
    enable_d   = mask_we ? mask_wdata : enable_q;
    prev_d     = irq_req;
    unique case (state_q)
      S_RUN: begin
        if (instr_valid && not_an_instr) begin
          state_d    = S_HANDLER;
          redirect_d = 1'b1;
          rpc_d      = VEC;
          elr_d      = pc_in;
          esr_d      = ESR_ILL;
          inh_d      = 1'b1;
        end else if (instr_valid && eret_in) begin
          state_d    = S_HANDLER;
          redirect_d = 1'b1;
          rpc_d      = VEC;
          elr_d      = pc_in;
          esr_d      = ESR_ERET;
          inh_d      = 1'b1;
        end else if (irq_hit) begin
          state_d    = S_HANDLER;
          redirect_d = 1'b1;
          rpc_d      = VEC;
          elr_d      = pc_in;
          esr_d      = ESR_IRQ;
          id_d       = irq_sel;
          ack_d      = irq_oh;
          inh_d      = 1'b1;
        end
      end
      S_HANDLER: begin
        if (instr_valid && not_an_instr) begin
          state_d = S_HALT;
          esr_d   = ESR_DBL;
          halt_d  = 1'b1;
          inh_d   = 1'b0;
        end else if (instr_valid && eret_in) begin
          state_d    = S_RUN;
          redirect_d = 1'b1;
          rpc_d      = elr_q;
          inh_d      = 1'b0;
        end
      end
      S_HALT: begin
        pending_d = pending_q;
        enable_d  = enable_q;
        prev_d    = prev_q;
      end
      default: state_d = S_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_RUN;
      pending_q  <= '0;
      enable_q   <= '1;
      prev_q     <= '0;
      redirect_q <= 1'b0;
      rpc_q      <= '0;
      elr_q      <= '0;
      esr_q      <= ESR_NONE;
      id_q       <= '0;
      ack_q      <= '0;
      inh_q      <= 1'b0;
      halt_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      enable_q   <= enable_d;
      prev_q     <= prev_d;
      redirect_q <= redirect_d;
      rpc_q      <= rpc_d;
      elr_q      <= elr_d;
      esr_q      <= esr_d;
      id_q       <= id_d;
      ack_q      <= ack_d;
      inh_q      <= inh_d;
      halt_q     <= halt_d;
    end
  end

  assign redirect    = redirect_q;
  assign redirect_pc = rpc_q;
  assign elr         = elr_q;
  assign esr         = esr_q;
  assign irq_id      = id_q;
  assign irq_ack     = ack_q;
  assign in_handler  = inh_q;
  assign halted      = halt_q;

endmodule
